// File: rtl/vend_pkg.sv
// Shared types, drink codes and prices for the coffee-machine transaction sequencer.
package vend_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    BREWING,
    PAYOUT,
    FAULT
  } state_e;

  localparam logic [2:0] DRINK_NONE   = 3'd0;
  localparam logic [2:0] DRINK_COFFEE = 3'd1;
  localparam logic [2:0] DRINK_MILK   = 3'd2;
  localparam logic [2:0] DRINK_CAPPU  = 3'd3;
  localparam logic [2:0] DRINK_MOCCA  = 3'd4;

  localparam logic [3:0] PRICE_COFFEE = 4'd3;
  localparam logic [3:0] PRICE_MILK   = 4'd4;
  localparam logic [3:0] PRICE_CAPPU  = 4'd5;
  localparam logic [3:0] PRICE_MOCCA  = 4'd6;

  function automatic logic [3:0] price_of(input logic [2:0] code);
    case (code)
      DRINK_COFFEE: price_of = PRICE_COFFEE;
      DRINK_MILK:   price_of = PRICE_MILK;
      DRINK_CAPPU:  price_of = PRICE_CAPPU;
      DRINK_MOCCA:  price_of = PRICE_MOCCA;
      default:      price_of = 4'd0;
    endcase
  endfunction

  // Anything other than exactly one switch closed is "no selection".
  function automatic logic [2:0] sel_to_code(input logic [3:0] sel);
    case (sel)
      4'b0001: sel_to_code = DRINK_COFFEE;
      4'b0010: sel_to_code = DRINK_MILK;
      4'b0100: sel_to_code = DRINK_CAPPU;
      4'b1000: sel_to_code = DRINK_MOCCA;
      default: sel_to_code = DRINK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/vend_controller_if.sv
// Coin/switch inputs and brew/payout outputs of the vending sequencer.
interface vend_controller_if;
  logic       coin_100;
  logic       coin_500;
  logic       cancel;
  logic [3:0] drink_sel;
  logic       brew_done;
  logic [3:0] credit;
  logic       brew_start;
  logic [2:0] brew_type;
  logic       coin_reject;
  logic       change_pulse;
  logic       busy;
  logic       fault;

  modport slave (
    input  coin_100, coin_500, cancel, drink_sel, brew_done,
    output credit, brew_start, brew_type, coin_reject, change_pulse, busy, fault
  );

  modport master (
    output coin_100, coin_500, cancel, drink_sel, brew_done,
    input  credit, brew_start, brew_type, coin_reject, change_pulse, busy, fault
  );
endinterface

// File: rtl/vend_controller_payout_pacer.sv
// Paces change coins: a tick on the first enabled cycle after start, then every GAP cycles.
module payout_pacer #(
  parameter int unsigned GAP = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int unsigned CW = $clog2(GAP);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = (cnt_q == '0) ? CW'(GAP - 1) : cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == '0);
endmodule

// File: rtl/vend_controller.sv
// Coin credit, drink purchase, brew hand-off with timeout, and coin-by-coin change payout.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_MAX   = 15,
  parameter int unsigned PAYOUT_GAP   = 50_000_000,
  parameter logic [31:0] BREW_TIMEOUT = 32'd3_000_000_000
) (
  input logic              clk,
  input logic              reset,
  vend_controller_if.slave bus
);
  state_e      state_q, state_d;
  logic [3:0]  credit_q, credit_d;
  logic [2:0]  brew_type_q, brew_type_d;
  logic [31:0] timer_q, timer_d;
  logic        brew_start_q, brew_start_d;
  logic        coin_reject_q, coin_reject_d;
  logic        change_pulse_q, change_pulse_d;
  logic        pacer_start, pacer_tick;

  logic [2:0]  sel_code;
  logic [3:0]  sel_price;
  logic        buy;
  logic [3:0]  base_credit;
  logic [2:0]  coin_val;
  logic [4:0]  coin_sum;
  logic        coins_in;

  // A purchase is settled first; the coin of the same cycle then lands on what is left.
  assign sel_code    = sel_to_code(bus.drink_sel);
  assign sel_price   = price_of(sel_code);
  assign buy         = (sel_code != DRINK_NONE) && (credit_q >= sel_price);
  assign base_credit = buy ? credit_q - sel_price : credit_q;
  assign coin_val    = bus.coin_500 ? 3'd5 : (bus.coin_100 ? 3'd1 : 3'd0);
  assign coin_sum    = {1'b0, base_credit} + {2'b00, coin_val};
  assign coins_in    = bus.coin_100 | bus.coin_500;

  payout_pacer #(.GAP(PAYOUT_GAP)) u_pacer (
    .clk    (clk),
    .reset  (reset),
    .start_i(pacer_start),
    .en_i   (state_q == PAYOUT),
    .tick_o (pacer_tick)
  );

  // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latch).
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    brew_type_d    = brew_type_q;
    timer_d        = timer_q;
    brew_start_d   = 1'b0;
    coin_reject_d  = 1'b0;
    change_pulse_d = 1'b0;
    pacer_start    = 1'b0;
    case (state_q)
      COLLECT: begin
        if (coin_sum > 5'(CREDIT_MAX)) begin
          credit_d      = base_credit;
          coin_reject_d = 1'b1;
        end else begin
          credit_d = coin_sum[3:0];
        end
        if (bus.coin_100 && bus.coin_500) coin_reject_d = 1'b1;
        if (buy) begin
          state_d      = BREWING;
          brew_type_d  = sel_code;
          brew_start_d = 1'b1;
          timer_d      = '0;
        end else if (bus.cancel && credit_q != 4'd0) begin
          state_d     = PAYOUT;
          pacer_start = 1'b1;
        end
      end
      BREWING: begin
        coin_reject_d = coins_in;
        if (bus.brew_done) begin
          if (credit_q != 4'd0) begin
            state_d     = PAYOUT;
            pacer_start = 1'b1;
          end else begin
            state_d     = COLLECT;
            brew_type_d = DRINK_NONE;
          end
        end else if (timer_q == BREW_TIMEOUT - 32'd1) begin
          state_d = FAULT;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      PAYOUT: begin
        coin_reject_d = coins_in;
        if (credit_q == 4'd0) begin
          state_d     = COLLECT;
          brew_type_d = DRINK_NONE;
        end else if (pacer_tick) begin
          credit_d       = credit_q - 4'd1;
          change_pulse_d = 1'b1;
        end
      end
      default: ;  // FAULT: frozen until reset
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= COLLECT;
      credit_q       <= 4'd0;
      brew_type_q    <= DRINK_NONE;
      timer_q        <= '0;
      brew_start_q   <= 1'b0;
      coin_reject_q  <= 1'b0;
      change_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      brew_type_q    <= brew_type_d;
      timer_q        <= timer_d;
      brew_start_q   <= brew_start_d;
      coin_reject_q  <= coin_reject_d;
      change_pulse_q <= change_pulse_d;
    end
  end

  always_comb begin
    bus.credit       = credit_q;
    bus.brew_start   = brew_start_q;
    bus.brew_type    = brew_type_q;
    bus.coin_reject  = coin_reject_q;
    bus.change_pulse = change_pulse_q;
    bus.busy         = (state_q != COLLECT);
    bus.fault        = (state_q == FAULT);
  end
endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
Transaction sequencer for the coffee machine. It accumulates coin credit, validates the drink selection against its price, and hands a one-cycle brew request to the ingredient FSM. It then waits for brew completion and pays out change (or a refund on cancel) one 100-unit coin at a time. It sits between the debounced coin/switch inputs and the brew FSM/timer, and replaces ad-hoc credit/compare glue at the top level.

Parameters:
CREDIT_MAX, 15, saturation limit of credit in 100-units (4-bit credit)
PAYOUT_GAP, 50_000_000, clk cycles between consecutive change_pulse outputs (min 2)
BREW_TIMEOUT, 32'd3_000_000_000, clk cycles allowed between brew_start and brew_done before fault

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high; clears all state
coin_100  in  1  one-cycle pulse, 100 coin inserted
coin_500  in  1  one-cycle pulse, 500 coin inserted
cancel  in  1  level/pulse, request refund
drink_sel  in  4  debounced switches, one-hot: [0]coffee [1]coffee+milk [2]cappuccino [3]mocca
brew_done  in  1  one-cycle pulse from brew FSM, dispensing finished
credit  out  4  current credit in 100-units (display source)
brew_start  out  1  one-cycle pulse, start brewing
brew_type  out  3  drink code held valid from brew_start until return to IDLE
coin_reject  out  1  one-cycle pulse, coin not accepted
change_pulse  out  1  one-cycle pulse per 100-unit coin returned
busy  out  1  high in BREWING and PAYOUT
fault  out  1  sticky brew-timeout indication

Behaviour:
- Reset: state=COLLECT, credit=0, brew_type=0, all pulses 0, busy=0, fault=0. Asynchronous assert; release takes effect on the next clk edge.
- Prices in 100-units: coffee 3, coffee+milk 4, cappuccino 5, mocca 6. Codes: 1,2,3,4; 0 = none.
- Selection is valid only when drink_sel has exactly one bit set. 0 or >1 bits means no purchase.
- COLLECT:
  - A coin pulse at edge N gives credit+1 or +5 at N+1.
  - If the result would exceed CREDIT_MAX, credit is unchanged and coin_reject=1 at N+1.
  - coin_100 and coin_500 in the same cycle: 500 is processed and 100 is rejected.
  - If the selection is valid and credit>=price: next edge sets credit=credit-price+(accepted coin, if any), latches brew_type, pulses brew_start=1 for one cycle, and moves to BREWING.
  - cancel with credit>0 goes to PAYOUT. cancel with credit=0 has no effect.
  - Purchase takes priority over cancel in the same cycle.
- BREWING:
  - busy=1. Coins are rejected (coin_reject pulses) and cancel is ignored.
  - brew_done goes to PAYOUT if credit>0, else to COLLECT with brew_type=0.
  - A timeout counter runs from brew_start. Reaching BREW_TIMEOUT goes to FAULT.
- PAYOUT:
  - busy=1. change_pulse fires on the first cycle after entry, then every PAYOUT_GAP cycles.
  - Each pulse decrements credit in the same edge.
  - When credit reaches 0, return to COLLECT the following edge with brew_type=0.
  - Coins are rejected and cancel is ignored.
- FAULT:
  - fault=1, busy=1, all inputs ignored, credit frozen. Exit only by reset.
- Reset mid-operation abandons the transaction with no payout and clears credit.
- brew_done outside BREWING is ignored.
- Credit arithmetic is 4-bit unsigned. Subtraction never underflows because it is guarded by the credit>=price check.

Decomposition:
- Shared package vend_pkg holds:
  - state enum COLLECT/BREWING/PAYOUT/FAULT
  - drink code constants
  - price constants
  - a price_of(code) function
- One sub-module, payout_pacer: a PAYOUT_GAP down-counter with start/tick ports that generates change_pulse timing.
- The BREW_TIMEOUT counter stays inline.

Test Plan (PAYOUT_GAP=4, BREW_TIMEOUT=100):
- Reset, coin_500 then coin_100 -> credit 5 then 6; coin_reject stays 0.
- credit=6, drink_sel=4'b0001 -> brew_start one cycle, brew_type=1, credit=3. brew_done -> 3 change_pulses spaced 4 cycles, credit 3→0, back to COLLECT.
- credit=4, drink_sel=4'b1000 (price 6) -> no brew_start. drink_sel=4'b0011 with credit 6 -> no brew_start (invalid selection).
- credit=14, coin_500 -> coin_reject=1, credit stays 14. coin_100 -> 15. Simultaneous coin_100+coin_500 at 10 -> credit 15, coin_reject=1.
- credit=2, cancel -> 2 change_pulses, busy high throughout, then COLLECT. Coin during PAYOUT -> coin_reject, credit unchanged.
- Purchase, no brew_done for 100 cycles -> fault=1, busy=1, state held. Assert reset mid-brew -> credit 0, fault 0 immediately.
